// File: rtl/pcie_tlp_pkg.sv
// Shared types for the PCIe TLP transmit path: arbiter state, source ids and
// the output register flavour used by the AXIS register stage.
package pcie_tlp_pkg;

  localparam int unsigned BEAT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CFG,
    ST_TLP
  } tlp_tx_arb_state_t;

  typedef enum logic {
    SRC_CFG,
    SRC_TLP
  } tlp_tx_src_e;

  typedef enum logic [1:0] {
    Bypass,
    SimpleReg,
    SkidBuffer
  } axis_reg_type_e;

  typedef struct packed {
    tlp_tx_arb_state_t       state;
    tlp_tx_src_e             last_grant;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
  } tlp_tx_arb_regs_t;

  // {tlp,cfg} one-hot encoding used on grant_o
  function automatic logic [1:0] src_onehot(input tlp_tx_src_e src);
    return (src == SRC_TLP) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pcie_tlp_tx_arbiter_axis_register.sv
// AXI-Stream register slice: bypass, simple half-rate register or full-rate
// skid buffer with a registered upstream ready.
module axis_register
  import pcie_tlp_pkg::*;
#(
  parameter int unsigned    DATA_WIDTH  = 32,
  parameter int unsigned    KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned    USER_WIDTH  = 1,
  parameter bit             KEEP_ENABLE = 1'b1,
  parameter bit             LAST_ENABLE = 1'b1,
  parameter bit             USER_ENABLE = 1'b1,
  parameter axis_reg_type_e REG_TYPE    = SkidBuffer
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready
);

  localparam int unsigned PW = 1 + USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

  logic [KEEP_WIDTH-1:0] in_tkeep;
  logic                  in_tlast;
  logic [USER_WIDTH-1:0] in_tuser;
  logic [PW-1:0]         in_pay;
  logic [PW-1:0]         out_pay;

  assign in_tkeep = KEEP_ENABLE ? s_axis_tkeep : '1;
  assign in_tlast = LAST_ENABLE ? s_axis_tlast : 1'b1;
  assign in_tuser = USER_ENABLE ? s_axis_tuser : '0;
  assign in_pay   = {in_tlast, in_tuser, in_tkeep, s_axis_tdata};

  assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_pay;

  if (REG_TYPE == SkidBuffer) begin : g_skid
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          tmp_valid_q, tmp_valid_d;
    logic [PW-1:0] m_pay_q, m_pay_d;
    logic [PW-1:0] tmp_pay_q, tmp_pay_d;

    // Ready is registered, so one beat may arrive after downstream stalls;
    // that beat parks in the temp slot until the output register frees up.
    always_comb begin
      m_valid_d   = m_valid_q;
      tmp_valid_d = tmp_valid_q;
      m_pay_d     = m_pay_q;
      tmp_pay_d   = tmp_pay_q;
      s_ready_d   = m_axis_tready || (!tmp_valid_q && (!m_valid_q || !s_axis_tvalid));
      if (s_ready_q) begin
        if (m_axis_tready || !m_valid_q) begin
          m_valid_d = s_axis_tvalid;
          m_pay_d   = in_pay;
        end else begin
          tmp_valid_d = s_axis_tvalid;
          tmp_pay_d   = in_pay;
        end
      end else if (m_axis_tready) begin
        m_valid_d   = tmp_valid_q;
        m_pay_d     = tmp_pay_q;
        tmp_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s_ready_q   <= 1'b0;
        m_valid_q   <= 1'b0;
        tmp_valid_q <= 1'b0;
        m_pay_q     <= '0;
        tmp_pay_q   <= '0;
      end else begin
        s_ready_q   <= s_ready_d;
        m_valid_q   <= m_valid_d;
        tmp_valid_q <= tmp_valid_d;
        m_pay_q     <= m_pay_d;
        tmp_pay_q   <= tmp_pay_d;
      end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign out_pay       = m_pay_q;
  end else if (REG_TYPE == SimpleReg) begin : g_simple
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [PW-1:0] m_pay_q, m_pay_d;

    always_comb begin
      m_valid_d = m_valid_q;
      m_pay_d   = m_pay_q;
      if (m_axis_tready) begin
        m_valid_d = 1'b0;
      end
      if (s_ready_q && s_axis_tvalid) begin
        m_valid_d = 1'b1;
        m_pay_d   = in_pay;
      end
      s_ready_d = !m_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s_ready_q <= 1'b0;
        m_valid_q <= 1'b0;
        m_pay_q   <= '0;
      end else begin
        s_ready_q <= s_ready_d;
        m_valid_q <= m_valid_d;
        m_pay_q   <= m_pay_d;
      end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign out_pay       = m_pay_q;
  end else begin : g_bypass
    assign s_axis_tready = m_axis_tready;
    assign m_axis_tvalid = s_axis_tvalid;
    assign out_pay       = in_pay;
  end

endmodule

// File: rtl/pcie_tlp_tx_arbiter.sv
// Packet-atomic merge of config-completion and memory/DMA TLP streams into a
// single AXIS stream toward the datalink TX path, via a skid-buffer output.
module pcie_tlp_tx_arbiter
  import pcie_tlp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned CFG_PRIORITY = 0,
  parameter int unsigned MAX_BEATS    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] s_cfg_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_cfg_axis_tkeep,
  input  logic                  s_cfg_axis_tvalid,
  input  logic                  s_cfg_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_cfg_axis_tuser,
  output logic                  s_cfg_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
  input  logic                  s_tlp_axis_tvalid,
  input  logic                  s_tlp_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
  output logic                  s_tlp_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [1:0]            grant_o,
  output logic                  err_oversize_o
);

  localparam logic [BEAT_CNT_W-1:0] MAX_CNT = BEAT_CNT_W'(MAX_BEATS);

  tlp_tx_arb_regs_t        regs_q, regs_d;
  logic                    err_q, err_d;
  tlp_tx_src_e             sel;
  logic                    sel_valid;
  logic                    ir;
  logic                    accept;
  logic [BEAT_CNT_W-1:0]   cnt_base;
  logic [BEAT_CNT_W-1:0]   cnt_next;

  logic [DATA_WIDTH-1:0]   fwd_tdata;
  logic [KEEP_WIDTH-1:0]   fwd_tkeep;
  logic                    fwd_tvalid;
  logic                    fwd_tlast;
  logic [USER_WIDTH-1:0]   fwd_tuser;

  always_comb begin
    regs_d    = regs_q;
    err_d     = 1'b0;
    sel       = SRC_CFG;
    sel_valid = 1'b0;

    case (regs_q.state)
      ST_CFG: begin
        sel       = SRC_CFG;
        sel_valid = 1'b1;
      end
      ST_TLP: begin
        sel       = SRC_TLP;
        sel_valid = 1'b1;
      end
      default: begin
        sel_valid = s_cfg_axis_tvalid || s_tlp_axis_tvalid;
        if (s_cfg_axis_tvalid && s_tlp_axis_tvalid) begin
          sel = ((CFG_PRIORITY != 0) || (regs_q.last_grant == SRC_TLP)) ? SRC_CFG : SRC_TLP;
        end else if (s_tlp_axis_tvalid) begin
          sel = SRC_TLP;
        end else begin
          sel = SRC_CFG;
        end
      end
    endcase

    if (sel == SRC_TLP) begin
      fwd_tdata  = s_tlp_axis_tdata;
      fwd_tkeep  = s_tlp_axis_tkeep;
      fwd_tvalid = s_tlp_axis_tvalid;
      fwd_tlast  = s_tlp_axis_tlast;
      fwd_tuser  = s_tlp_axis_tuser;
    end else begin
      fwd_tdata  = s_cfg_axis_tdata;
      fwd_tkeep  = s_cfg_axis_tkeep;
      fwd_tvalid = s_cfg_axis_tvalid;
      fwd_tlast  = s_cfg_axis_tlast;
      fwd_tuser  = s_cfg_axis_tuser;
    end

    s_cfg_axis_tready = ir && sel_valid && (sel == SRC_CFG);
    s_tlp_axis_tready = ir && sel_valid && (sel == SRC_TLP);
    accept            = fwd_tvalid && ir;
    grant_o           = sel_valid ? src_onehot(sel) : 2'b00;

    // The first beat of a packet is accepted in idle, so count from zero there.
    cnt_base = (regs_q.state == ST_IDLE) ? '0 : regs_q.beat_cnt;
    cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;

    if (accept) begin
      regs_d.last_grant = sel;
      if (fwd_tlast) begin
        regs_d.state    = ST_IDLE;
        regs_d.beat_cnt = '0;
      end else begin
        regs_d.state    = (sel == SRC_CFG) ? ST_CFG : ST_TLP;
        regs_d.beat_cnt = cnt_next;
        err_d           = (cnt_next == MAX_CNT) && (cnt_base != MAX_CNT);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{state: ST_IDLE, last_grant: SRC_TLP, beat_cnt: '0};
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  assign err_oversize_o = err_q;

  axis_register #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KEEP_WIDTH  (KEEP_WIDTH),
    .USER_WIDTH  (USER_WIDTH),
    .KEEP_ENABLE (1'b1),
    .LAST_ENABLE (1'b1),
    .USER_ENABLE (1'b1),
    .REG_TYPE    (SkidBuffer)
  ) u_out_reg (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .s_axis_tdata  (fwd_tdata),
    .s_axis_tkeep  (fwd_tkeep),
    .s_axis_tvalid (fwd_tvalid),
    .s_axis_tlast  (fwd_tlast),
    .s_axis_tuser  (fwd_tuser),
    .s_axis_tready (ir),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready)
  );

endmodule
